// File: rtl/adder_bist_sequencer.sv
// -----------------------------------------------------------------------------
// adder_bist_sequencer
//
// Built-in self-test sequencer for a fixed-point adder that sits outside this
// block. It reads a vector memory of packed {A, B, expected_sum, expected_ovf}
// words one at a time and drives A/B onto the adder. After the operands have
// settled, it compares the adder's sum and overflow flag against the expected
// values. At the end of a pass it reports pass/fail, the number of failing
// vectors and the index of the first failing vector.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   start           1-cycle pulse that begins a pass (ignored while busy)
//   vec_addr        vector memory read address
//   vec_rd          read strobe; vec_data is valid on the following cycle
//   vec_data        {A, B, expected_sum, expected_ovf}
//   op_a, op_b      operands driven to the adder under test
//   add_result      adder sum (combinational from op_a/op_b)
//   add_overflow    adder overflow flag
//   busy            pass in progress
//   done            pass complete; held until the next accepted start or rst
//   pass            valid with done: no mismatching vectors
//   fail_count      mismatching vectors this pass, saturating
//   first_fail_idx  index of the first mismatch; all-ones if none
// -----------------------------------------------------------------------------
module adder_bist_sequencer #(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_VECTORS   = 100,
    parameter int ADDR_WIDTH    = 7,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [ADDR_WIDTH-1:0]   vec_addr,
    output logic                    vec_rd,
    input  logic [3*DATA_WIDTH:0]   vec_data,
    output logic [DATA_WIDTH-1:0]   op_a,
    output logic [DATA_WIDTH-1:0]   op_b,
    input  logic [DATA_WIDTH-1:0]   add_result,
    input  logic                    add_overflow,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ADDR_WIDTH:0]     fail_count,
    output logic [ADDR_WIDTH-1:0]   first_fail_idx
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]         SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [CW-1:0]           settle_cnt;
    logic [DATA_WIDTH-1:0]   exp_q;
    logic                    exp_ovf_q;
    logic                    mismatch;

    // Raw-bit compare; sign interpretation belongs to the adder, not here.
    assign mismatch = (add_result != exp_q) || (add_overflow != exp_ovf_q);

    // The address register doubles as the vector index, so after a pass it
    // holds the last index that was run.
    assign vec_addr = idx;
    assign vec_rd   = (state == S_FETCH);

    // NOTE: reset is sampled on the clock edge (synchronous), and every
    // register in an always_ff is updated with <= so that all of them see the
    // values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: state_nxt gets its default before the case statement. Otherwise
    // any path that does not assign it would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_SETTLE;
            S_SETTLE: if (settle_cnt == '0) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = (idx == LAST_IDX) ? S_FINISH : S_FETCH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            settle_cnt     <= '0;
            op_a           <= '0;
            op_b           <= '0;
            exp_q          <= '0;
            exp_ovf_q      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx            <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        fail_count     <= '0;
                        first_fail_idx <= '1;
                    end
                end
                S_LOAD: begin
                    op_a       <= vec_data[3*DATA_WIDTH -: DATA_WIDTH];
                    op_b       <= vec_data[2*DATA_WIDTH -: DATA_WIDTH];
                    exp_q      <= vec_data[DATA_WIDTH:1];
                    exp_ovf_q  <= vec_data[0];
                    settle_cnt <= SETTLE_LOAD;
                end
                S_SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (fail_count != '1) fail_count <= fail_count + 1'b1;
                        if (fail_count == '0) first_fail_idx <= idx;
                    end
                    // Index stops at the last vector instead of wrapping.
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                S_FINISH: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (fail_count == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adder_bist_sequencer
//
// Two sequencers share clk/rst:
//   u0 runs with the defaults (100 vectors, 1 settle cycle).
//   u1 runs with 4 vectors and 3 settle cycles.
// Each unit has a synchronous-read vector memory and an ideal adder. The ideal
// adder's overflow flag can be forced to zero.
//
// A per-unit model tracks the timeline of a pass (cycles since the accepted
// start) and computes the expected counts from the memory contents. One
// negedge process compares every output against the model on every cycle.
// -----------------------------------------------------------------------------
module tb_adder_bist_sequencer;

    localparam int DW = 16;
    localparam int AW = 7;
    localparam int N0 = 100;
    localparam int S0 = 1;
    localparam int N1 = 4;
    localparam int S1 = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      start = '0;
    logic [1:0]      force_ovf0 = '0;
    logic [AW-1:0]   vec_addr_s [2];
    logic [1:0]      vec_rd_s;
    logic [3*DW:0]   vec_data_s [2];
    logic [DW-1:0]   op_a_s [2];
    logic [DW-1:0]   op_b_s [2];
    logic [DW-1:0]   add_result_s [2];
    logic [1:0]      add_ovf_s;
    logic [1:0]      busy_s;
    logic [1:0]      done_s;
    logic [1:0]      pass_s;
    logic [AW:0]     fc_s [2];
    logic [AW-1:0]   ffi_s [2];
    logic [3*DW:0]   mem [2][128];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic ideal_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] s;
        s = a + b;
        return (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
    endfunction

    function automatic logic [3*DW:0] mk_vec(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] s;
        s = a + b;
        return {a, b, s, ideal_ovf(a, b)};
    endfunction

    // Adders under test (external to the sequencer).
    assign add_result_s[0] = op_a_s[0] + op_b_s[0];
    assign add_result_s[1] = op_a_s[1] + op_b_s[1];
    assign add_ovf_s[0]    = force_ovf0[0] ? 1'b0 : ideal_ovf(op_a_s[0], op_b_s[0]);
    assign add_ovf_s[1]    = force_ovf0[1] ? 1'b0 : ideal_ovf(op_a_s[1], op_b_s[1]);

    // Synchronous-read vector memories.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++)
            if (vec_rd_s[u]) vec_data_s[u] <= mem[u][vec_addr_s[u]];
    end

    adder_bist_sequencer #(
        .DATA_WIDTH(DW), .NUM_VECTORS(N0), .ADDR_WIDTH(AW), .SETTLE_CYCLES(S0)
    ) u0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .vec_addr(vec_addr_s[0]), .vec_rd(vec_rd_s[0]), .vec_data(vec_data_s[0]),
        .op_a(op_a_s[0]), .op_b(op_b_s[0]),
        .add_result(add_result_s[0]), .add_overflow(add_ovf_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .fail_count(fc_s[0]), .first_fail_idx(ffi_s[0])
    );

    adder_bist_sequencer #(
        .DATA_WIDTH(DW), .NUM_VECTORS(N1), .ADDR_WIDTH(AW), .SETTLE_CYCLES(S1)
    ) u1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .vec_addr(vec_addr_s[1]), .vec_rd(vec_rd_s[1]), .vec_data(vec_data_s[1]),
        .op_a(op_a_s[1]), .op_b(op_b_s[1]),
        .add_result(add_result_s[1]), .add_overflow(add_ovf_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .fail_count(fc_s[1]), .first_fail_idx(ffi_s[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_NONE, M_RST, M_BUSY, M_DONE} mmode_t;

    mmode_t      mmode [2] = '{M_NONE, M_NONE};
    int          mk    [2];
    logic [AW:0]   m_fc  [2];
    logic [AW-1:0] m_ffi [2];

    function automatic int nv(input int u);
        return (u == 0) ? N0 : N1;
    endfunction

    function automatic int per(input int u);
        return 3 + ((u == 0) ? S0 : S1);
    endfunction

    // Expected pass outcome, computed from the memory contents and the adder behaviour.
    task automatic model_pass(input int u);
        logic [3*DW:0] w;
        logic [DW-1:0] a, b, s;
        logic          o;
        m_fc[u]  = '0;
        m_ffi[u] = '1;
        for (int i = 0; i < nv(u); i++) begin
            w = mem[u][i];
            a = w[3*DW -: DW];
            b = w[2*DW -: DW];
            s = a + b;
            o = force_ovf0[u] ? 1'b0 : ideal_ovf(a, b);
            if (s != w[DW:1] || o != w[0]) begin
                if (m_fc[u] == '0) m_ffi[u] = AW'(i);
                if (m_fc[u] != '1) m_fc[u] = m_fc[u] + 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                mmode[u] = M_RST;
            end else if (start[u] && mmode[u] != M_BUSY) begin
                model_pass(u);
                mmode[u] = M_BUSY;
                mk[u]    = 0;
            end else if (mmode[u] == M_BUSY) begin
                mk[u]++;
                if (mk[u] == 1 + nv(u) * per(u)) mmode[u] = M_DONE;
            end
        end
    end

    // Single compare process.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            int i, ph;
            logic [3*DW:0] w;
            case (mmode[u])
                M_RST: begin
                    check($sformatf("u%0d rst busy", u), 64'(busy_s[u]), 64'(0));
                    check($sformatf("u%0d rst done", u), 64'(done_s[u]), 64'(0));
                    check($sformatf("u%0d rst pass", u), 64'(pass_s[u]), 64'(0));
                    check($sformatf("u%0d rst fail_count", u), 64'(fc_s[u]), 64'(0));
                    check($sformatf("u%0d rst first_fail_idx", u), 64'(ffi_s[u]), 64'(7'h7F));
                    check($sformatf("u%0d rst op_a", u), 64'(op_a_s[u]), 64'(0));
                    check($sformatf("u%0d rst op_b", u), 64'(op_b_s[u]), 64'(0));
                    check($sformatf("u%0d rst vec_rd", u), 64'(vec_rd_s[u]), 64'(0));
                end
                M_BUSY: begin
                    check($sformatf("u%0d busy k=%0d", u, mk[u]), 64'(busy_s[u]), 64'(1));
                    check($sformatf("u%0d done low k=%0d", u, mk[u]), 64'(done_s[u]), 64'(0));
                    check($sformatf("u%0d pass low k=%0d", u, mk[u]), 64'(pass_s[u]), 64'(0));
                    if (mk[u] < nv(u) * per(u)) begin
                        i  = mk[u] / per(u);
                        ph = mk[u] % per(u);
                        w  = mem[u][i];
                        check($sformatf("u%0d vec_rd k=%0d", u, mk[u]), 64'(vec_rd_s[u]), 64'(ph == 0));
                        if (ph == 0)
                            check($sformatf("u%0d vec_addr k=%0d", u, mk[u]), 64'(vec_addr_s[u]), 64'(i));
                        if (ph >= 2) begin
                            check($sformatf("u%0d op_a k=%0d", u, mk[u]), 64'(op_a_s[u]), 64'(w[3*DW -: DW]));
                            check($sformatf("u%0d op_b k=%0d", u, mk[u]), 64'(op_b_s[u]), 64'(w[2*DW -: DW]));
                        end
                    end else begin
                        check($sformatf("u%0d vec_rd finish", u), 64'(vec_rd_s[u]), 64'(0));
                    end
                end
                M_DONE: begin
                    w = mem[u][nv(u) - 1];
                    check($sformatf("u%0d done busy", u), 64'(busy_s[u]), 64'(0));
                    check($sformatf("u%0d done", u), 64'(done_s[u]), 64'(1));
                    check($sformatf("u%0d done pass", u), 64'(pass_s[u]), 64'(m_fc[u] == '0));
                    check($sformatf("u%0d done fail_count", u), 64'(fc_s[u]), 64'(m_fc[u]));
                    check($sformatf("u%0d done first_fail_idx", u), 64'(ffi_s[u]), 64'(m_ffi[u]));
                    check($sformatf("u%0d done op_a", u), 64'(op_a_s[u]), 64'(w[3*DW -: DW]));
                    check($sformatf("u%0d done op_b", u), 64'(op_b_s[u]), 64'(w[2*DW -: DW]));
                    check($sformatf("u%0d done vec_rd", u), 64'(vec_rd_s[u]), 64'(0));
                end
                default: ;
            endcase
        end
    end

    // ---------------- directed stimulus ----------------
    // Pulse start for one cycle, then count edges until done rises.
    task automatic run_pass(input int u, output int lat);
        @(negedge clk);
        start[u] = 1'b1;
        @(posedge clk);
        #1 start[u] = 1'b0;
        check($sformatf("u%0d start clears done", u), 64'(done_s[u]), 64'(0));
        lat = 0;
        while (done_s[u] !== 1'b1 && lat < 2000) begin
            @(posedge clk);
            #1 lat++;
        end
        check($sformatf("u%0d done reached", u), 64'(done_s[u]), 64'(1));
    endtask

    initial begin
        int lat, rises, first;
        logic prev;

        for (int i = 0; i < 128; i++) begin
            logic [DW-1:0] a, b;
            a = DW'(i * 1237 + 256);
            b = DW'((i * 4099) ^ 16'h3C5A);
            mem[0][i] = mk_vec(a, b);
            mem[1][i] = '0;
        end
        mem[0][7] = mk_vec(16'h7FFF, 16'h0001);
        mem[1][0] = mk_vec(16'h7FFF, 16'h0001);
        mem[1][1] = mk_vec(16'h0001, 16'h0002);
        mem[1][2] = mk_vec(16'h1234, 16'h4321);
        mem[1][3] = mk_vec(16'hF000, 16'h0100);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset first_fail_idx literal", 64'(ffi_s[0]), 64'(7'h7F));
        check("reset busy literal", 64'(busy_s[0]), 64'(0));

        // All vectors match.
        run_pass(0, lat);
        check("t1 latency", 64'(lat), 64'(401));
        check("t1 pass", 64'(pass_s[0]), 64'(1));
        check("t1 fail_count", 64'(fc_s[0]), 64'(0));
        check("t1 first_fail_idx", 64'(ffi_s[0]), 64'(7'h7F));

        // Two corrupted expected sums.
        mem[0][5][1]  = ~mem[0][5][1];
        mem[0][42][1] = ~mem[0][42][1];
        run_pass(0, lat);
        check("t2 fail_count", 64'(fc_s[0]), 64'(2));
        check("t2 first_fail_idx", 64'(ffi_s[0]), 64'(5));
        check("t2 pass", 64'(pass_s[0]), 64'(0));
        mem[0][5][1] = ~mem[0][5][1];

        // Reset during the SETTLE of vector 37, then a fresh pass.
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (37 * 4 + 2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t4 busy after rst", 64'(busy_s[0]), 64'(0));
        check("t4 fail_count after rst", 64'(fc_s[0]), 64'(0));
        run_pass(0, lat);
        check("t4 latency", 64'(lat), 64'(401));
        check("t4 fail_count", 64'(fc_s[0]), 64'(1));
        check("t4 first_fail_idx", 64'(ffi_s[0]), 64'(42));
        mem[0][42][1] = ~mem[0][42][1];

        // Start re-pulsed during vector 10 is ignored.
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        rises = 0;
        first = 0;
        prev  = done_s[0];
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk);
            #1 start[0] = (k == 41);
            if (done_s[0] && !prev) begin
                rises++;
                if (first == 0) first = k;
            end
            prev = done_s[0];
        end
        start[0] = 1'b0;
        check("t5 done rises once", 64'(rises), 64'(1));
        check("t5 latency", 64'(first), 64'(401));
        run_pass(0, lat);
        check("t5 second latency", 64'(lat), 64'(401));
        check("t5 second pass", 64'(pass_s[0]), 64'(1));

        // Overflow-only mismatch on vector 0 of u1.
        force_ovf0[1] = 1'b1;
        run_pass(1, lat);
        check("t3 latency", 64'(lat), 64'(25));
        check("t3 fail_count", 64'(fc_s[1]), 64'(1));
        check("t3 first_fail_idx", 64'(ffi_s[1]), 64'(0));
        check("t3 pass", 64'(pass_s[1]), 64'(0));

        // Longer settle window, all vectors match.
        force_ovf0[1] = 1'b0;
        run_pass(1, lat);
        check("t6 latency", 64'(lat), 64'(25));
        check("t6 pass", 64'(pass_s[1]), 64'(1));
        check("t6 first_fail_idx", 64'(ffi_s[1]), 64'(7'h7F));

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
